// File: rtl/aes_ks_pkg.sv
// Shared definitions for the AES key-schedule controller: state encodings,
// round counts, Rcon constants, the xtime helper and the AES S-box table.
// Optional feature macro: AES_KS_REVERSE_EN (adds FILL/DRAIN states).
package aes_ks_pkg;

  localparam int NR_128 = 10;
  localparam int NR_256 = 14;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  // Controller states, kept as plain constants for legacy tooling.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_EMIT  = 3'd2;
  localparam state_t ST_CALC  = 3'd3;
`ifdef AES_KS_REVERSE_EN
  localparam state_t ST_FILL  = 3'd4;
  localparam state_t ST_DRAIN = 3'd5;
`endif

  // GF(2^8) multiply by x, used to step Rcon.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[x];
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_g_function.sv
// AES key-schedule g function: RotWord, SubWord, then XOR Rcon into the
// leading byte. Passing rc=0 yields a rotated SubWord for AES-256 odd keys.
module g_function
  import aes_ks_pkg::*;
(
  input  logic [31:0] w,
  input  logic [7:0]  rc,
  output logic [31:0] g
);

  logic [31:0] rot;
  logic [31:0] sub;

  assign rot = {w[23:0], w[31:24]};

  // One S-box lookup per byte lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign sub[gi*8 +: 8] = sbox(rot[gi*8 +: 8]);
  end

  assign g = sub ^ {rc, 24'h000000};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128/256 key-expansion controller. One shared g_function
// produces one round key per CALC cycle; keys stream out on rk_valid/rk_ready.
// Optional feature macro: AES_KS_REVERSE_EN (buffered last-to-first emission).
module aes_key_sched_ctrl
  import aes_ks_pkg::*;
#(
  parameter int NR_MAX = 14,
  parameter int RK_W   = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            key_len,
  input  logic [255:0]    key,
  input  logic            reverse,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic [RK_W-1:0] rk_data,
  output logic [3:0]      rk_index,
  output logic            rk_last,
  output logic            busy,
  output logic            done
);

  localparam logic [3:0] NR_LO = 4'(NR_128);
  localparam logic [3:0] NR_HI = 4'((NR_MAX < NR_256) ? NR_MAX : NR_256);

  state_t          state_reg, state_next;
  logic [RK_W-1:0] a_reg, a_next;     // older key (rk[idx-1] / key copy)
  logic [RK_W-1:0] b_reg, b_next;     // newer key (rk[idx] for idx>=1)
  logic [7:0]      rcon_reg, rcon_next;
  logic [3:0]      idx_reg, idx_next;
  logic            len_reg, len_next;
  logic            done_reg, done_next;

  logic [3:0]      nr;
  logic [3:0]      idx_inc;
  logic [RK_W-1:0] cur_key;
  logic            use_rcon;
  logic [7:0]      g_rc;
  logic [31:0]     g_out;
  logic [31:0]     t_word;
  logic [31:0]     nw0, nw1, nw2, nw3;
  logic [RK_W-1:0] new_key;
  logic            skip_calc;
  logic            hs;

`ifdef AES_KS_REVERSE_EN
  logic            rev_reg, rev_next;
  logic [3:0]      ridx_reg, ridx_next;
  logic            dvalid_reg, dvalid_next;
  logic [RK_W-1:0] key_buf [0:NR_MAX];
  logic [RK_W-1:0] buf_rd_reg;
`else
  logic            reverse_unused;
  assign reverse_unused = reverse;
`endif

  assign nr        = len_reg ? NR_HI : NR_LO;
  assign idx_inc   = idx_reg + 4'd1;
  assign cur_key   = (idx_reg == 4'd0) ? a_reg : b_reg;
  // AES-256 odd keys use SubWord only; everything else uses full g with Rcon.
  assign use_rcon  = !len_reg || !idx_inc[0];
  assign g_rc      = use_rcon ? rcon_reg : 8'h00;
  assign t_word    = use_rcon ? g_out : {g_out[7:0], g_out[31:8]};
  // AES-256 idx0 -> idx1 just exposes the second key half, no compute.
  assign skip_calc = len_reg && (idx_reg == 4'd0);

  g_function u_g (
    .w  (b_reg[31:0]),
    .rc (g_rc),
    .g  (g_out)
  );

  assign nw0     = a_reg[127:96] ^ t_word;
  assign nw1     = a_reg[95:64]  ^ nw0;
  assign nw2     = a_reg[63:32]  ^ nw1;
  assign nw3     = a_reg[31:0]   ^ nw2;
  assign new_key = {nw0, nw1, nw2, nw3};

`ifdef AES_KS_REVERSE_EN
  assign rk_valid = (state_reg == ST_EMIT) || ((state_reg == ST_DRAIN) && dvalid_reg);
  assign rk_data  = (state_reg == ST_DRAIN) ? buf_rd_reg : cur_key;
  assign rk_index = (state_reg == ST_DRAIN) ? ridx_reg : idx_reg;
  assign rk_last  = ((state_reg == ST_EMIT) && (idx_reg == nr)) ||
                    ((state_reg == ST_DRAIN) && dvalid_reg && (ridx_reg == 4'd0));
`else
  assign rk_valid = (state_reg == ST_EMIT);
  assign rk_data  = cur_key;
  assign rk_index = idx_reg;
  assign rk_last  = (state_reg == ST_EMIT) && (idx_reg == nr);
`endif

  assign hs   = rk_valid && rk_ready;
  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;

  // Next-state and datapath update for the expansion sequencer.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    rcon_next  = rcon_reg;
    idx_next   = idx_reg;
    len_next   = len_reg;
    done_next  = 1'b0;
`ifdef AES_KS_REVERSE_EN
    rev_next    = rev_reg;
    ridx_next   = ridx_reg;
    dvalid_next = dvalid_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          // Key and mode are captured here so later input changes are inert.
          state_next = ST_LOAD;
          len_next   = key_len;
          a_next     = key[255:128];
          b_next     = key_len ? key[127:0] : key[255:128];
          rcon_next  = RCON_INIT;
          idx_next   = 4'd0;
`ifdef AES_KS_REVERSE_EN
          rev_next   = reverse;
`endif
        end
      end
      ST_LOAD: begin
`ifdef AES_KS_REVERSE_EN
        state_next = rev_reg ? ST_FILL : ST_EMIT;
`else
        state_next = ST_EMIT;
`endif
      end
      ST_EMIT: begin
        if (hs) begin
          if (idx_reg == nr) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else if (skip_calc) begin
            idx_next = 4'd1;
          end else begin
            state_next = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        a_next   = len_reg ? b_reg : new_key;
        b_next   = new_key;
        idx_next = idx_inc;
        if (use_rcon) rcon_next = xtime(rcon_reg);
        state_next = ST_EMIT;
      end
`ifdef AES_KS_REVERSE_EN
      ST_FILL: begin
        // Current key is written to the buffer while the next one is computed.
        if (idx_reg == nr) begin
          state_next  = ST_DRAIN;
          ridx_next   = nr;
          dvalid_next = 1'b0;
        end else if (skip_calc) begin
          idx_next = 4'd1;
        end else begin
          a_next   = len_reg ? b_reg : new_key;
          b_next   = new_key;
          idx_next = idx_inc;
          if (use_rcon) rcon_next = xtime(rcon_reg);
        end
      end
      ST_DRAIN: begin
        // One fetch cycle per key to cover the registered buffer read.
        if (!dvalid_reg) begin
          dvalid_next = 1'b1;
        end else if (rk_ready) begin
          if (ridx_reg == 4'd0) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            ridx_next   = ridx_reg - 4'd1;
            dvalid_next = 1'b0;
          end
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Controller state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      rcon_reg  <= RCON_INIT;
      idx_reg   <= 4'd0;
      len_reg   <= 1'b0;
      done_reg  <= 1'b0;
`ifdef AES_KS_REVERSE_EN
      rev_reg    <= 1'b0;
      ridx_reg   <= 4'd0;
      dvalid_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      rcon_reg  <= rcon_next;
      idx_reg   <= idx_next;
      len_reg   <= len_next;
      done_reg  <= done_next;
`ifdef AES_KS_REVERSE_EN
      rev_reg    <= rev_next;
      ridx_reg   <= ridx_next;
      dvalid_reg <= dvalid_next;
`endif
    end
  end

`ifdef AES_KS_REVERSE_EN
  // Round-key buffer: write during FILL, registered read for DRAIN.
  always_ff @(posedge clk) begin
    if (state_reg == ST_FILL) key_buf[idx_reg] <= cur_key;
    buf_rd_reg <= key_buf[ridx_reg];
  end
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl using FIPS-197 key-expansion vectors.
// Build with AES_KS_REVERSE_EN defined to exercise reverse emission.
module tb_aes_key_sched_ctrl;

`ifdef AES_KS_REVERSE_EN
  localparam bit REV_EN = 1'b1;
`else
  localparam bit REV_EN = 1'b0;
`endif

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         key_len;
  logic [255:0] key;
  logic         reverse;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         rk_last;
  logic         busy;
  logic         done;

  aes_key_sched_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_len  (key_len),
    .key      (key),
    .reverse  (reverse),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_index (rk_index),
    .rk_last  (rk_last),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  logic [127:0] exp128 [0:10];
  logic [127:0] exp256 [0:14];
  bit           known256 [0:14];

  logic [127:0] cap_data [0:15];
  int           cap_idx  [0:15];
  bit           cap_last [0:15];
  int           n_cap;
  int           done_pulses;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts one expansion and consumes keys until done (or reset injection).
  task automatic run_seq(input bit len, input bit rev, input int stall_pct,
                         input int inj_idx, input int rst_idx, output bit aborted);
    int           last_hs;
    int           post;
    bit           stalled;
    bit           injected;
    logic [127:0] hold_d;
    logic [3:0]   hold_i;
    n_cap = 0; done_pulses = 0; last_hs = -10; post = -1;
    stalled = 0; injected = 0; aborted = 0; hold_d = '0; hold_i = '0;
    start = 1; key_len = len; key = len ? K256 : K128; reverse = rev;
    @(negedge clk);
    start = 0; key = ~key; key_len = ~len; reverse = ~rev;
    check("busy_in_load", busy, 1);
    check("valid_in_load", rk_valid, 0);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start = 0;
      rk_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
      if (c == 0 && !(rev && REV_EN)) check("first_valid_latency", rk_valid, 1);
      if (done) begin
        done_pulses++;
        if (done_pulses == 1) check("done_timing", c, last_hs + 1);
        if (post < 0) post = c;
      end
      if (rst_idx >= 0 && rk_valid && rk_index == 4'(rst_idx)) begin
        rst_n = 0;
        #1;
        check("rst_valid", rk_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", rk_data, 0);
        check("rst_index", rk_index, 0);
        check("rst_last", rk_last, 0);
        @(negedge clk);
        check("rst_no_done", done, 0);
        rst_n = 1;
        @(negedge clk);
        check("rst_no_done2", done, 0);
        aborted = 1;
        return;
      end
      if (stalled) begin
        check("hold_valid", rk_valid, 1);
        check("hold_data", rk_data, hold_d);
        check("hold_index", rk_index, hold_i);
        stalled = 0;
      end
      if (rk_valid) begin
        if (rk_ready) begin
          if (n_cap < 16) begin
            cap_data[n_cap] = rk_data;
            cap_idx[n_cap]  = int'(rk_index);
            cap_last[n_cap] = rk_last;
          end
          n_cap++;
          last_hs = c;
        end else begin
          stalled = 1;
          hold_d  = rk_data;
          hold_i  = rk_index;
        end
      end
      if (inj_idx >= 0 && !injected && rk_valid && rk_index == 4'(inj_idx)) begin
        start = 1;
        injected = 1;
      end
      if (post >= 0 && c >= post + 3) break;
    end
    rk_ready = 0;
    if (post < 0) check("done_timeout", 0, 1);
  endtask

  // Compares the captured stream against the reference key table.
  task automatic verify(input string name, input bit len, input bit rev_eff);
    int nk;
    int e;
    nk = len ? 15 : 11;
    check({name, "_nkeys"}, n_cap, nk);
    check({name, "_done_count"}, done_pulses, 1);
    for (int i = 0; i < n_cap && i < nk; i++) begin
      e = rev_eff ? nk - 1 - i : i;
      check($sformatf("%s_idx%0d", name, i), cap_idx[i], e);
      check($sformatf("%s_last%0d", name, i), cap_last[i], (i == nk - 1));
      if (!len) check($sformatf("%s_rk%0d", name, e), cap_data[i], exp128[e]);
      else if (known256[e]) check($sformatf("%s_rk%0d", name, e), cap_data[i], exp256[e]);
    end
  endtask

  initial begin
    bit ab;
    checks = 0; failures = 0;
    exp128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp128[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 15; i++) begin
      exp256[i] = '0;
      known256[i] = 0;
    end
    exp256[0]  = 128'h603deb1015ca71be2b73aef0857d7781; known256[0]  = 1;
    exp256[1]  = 128'h1f352c073b6108d72d9810a30914dff4; known256[1]  = 1;
    exp256[2]  = 128'h9ba354118e6925afa51a8b5f2067fcde; known256[2]  = 1;
    exp256[3]  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a; known256[3]  = 1;
    exp256[14] = 128'hfe4890d1e6188d0b046df344706c631e; known256[14] = 1;

    rst_n = 0; start = 0; key_len = 0; key = '0; reverse = 0; rk_ready = 0;
    repeat (2) @(negedge clk);
    check("reset_valid", rk_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_data", rk_data, 0);
    check("reset_index", rk_index, 0);
    check("reset_last", rk_last, 0);
    rst_n = 1;
    @(negedge clk);

    run_seq(1'b0, 1'b0, 0, -1, -1, ab);
    verify("aes128", 1'b0, 1'b0);
    $display("txn aes128 keys=%0d", n_cap);

    run_seq(1'b1, 1'b0, 0, -1, -1, ab);
    verify("aes256", 1'b1, 1'b0);
    $display("txn aes256 keys=%0d", n_cap);

    run_seq(1'b0, 1'b0, 50, -1, -1, ab);
    verify("aes128_stall", 1'b0, 1'b0);
    $display("txn aes128_stall keys=%0d", n_cap);

    run_seq(1'b1, 1'b0, 50, -1, -1, ab);
    verify("aes256_stall", 1'b1, 1'b0);
    $display("txn aes256_stall keys=%0d", n_cap);

    run_seq(1'b0, 1'b0, 0, 4, -1, ab);
    verify("start_in_busy", 1'b0, 1'b0);
    $display("txn start_in_busy keys=%0d", n_cap);

    run_seq(1'b1, 1'b0, 0, -1, 6, ab);
    check("rst_aborted", ab, 1);
    check("rst_keys_before", n_cap, 6);
    check("rst_done_count", done_pulses, 0);
    $display("txn reset_mid keys=%0d", n_cap);

    run_seq(1'b0, 1'b0, 0, -1, -1, ab);
    verify("after_reset", 1'b0, 1'b0);
    $display("txn after_reset keys=%0d", n_cap);

    run_seq(1'b0, 1'b1, 0, -1, -1, ab);
    verify("reverse128", 1'b0, REV_EN);
    $display("txn reverse128 keys=%0d", n_cap);

    run_seq(1'b1, 1'b1, 30, -1, -1, ab);
    verify("reverse256", 1'b1, REV_EN);
    $display("txn reverse256 keys=%0d", n_cap);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
